// File: rtl/run_host.sv
// run_host -- host-side initiator for the processor's req/done handshake.
//
// One session: preload LOAD_N operand bytes into data memory while the core
// is held in reset, release the core and pulse req, wait for done, then
// stream RES_N result bytes out of data memory through a valid/ready port.
//
// Ports
//   clk, reset        single clock; synchronous active-high reset
//   start             begin a session (sampled in IDLE, DONE_S, TMO only)
//   ld_valid/ld_data/ld_ready           load byte stream (host is sink)
//   mem_wr_en/mem_addr/mem_wdata/mem_rdata  shared data-memory port;
//                                        mem_rdata is combinational on mem_addr
//   core_reset, req, done                processor control handshake
//   res_valid/res_data/res_addr/res_ready   result byte stream (host is source)
//   busy, finished, timeout, run_cycles  status
//
// Optional feature: define HOST_TIMEOUT_EN to enable the WAIT watchdog
// (limit TMO_CYC cycles). Without it WAIT persists until done, the TMO state
// is unreachable and timeout is tied to 0.

module run_host #(
  parameter int AW        = 8,
  parameter int LOAD_BASE = 0,
  parameter int LOAD_N    = 64,
  parameter int RES_BASE  = 64,
  parameter int RES_N     = 32,
  parameter int TMO_CYC   = 4096
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          ld_valid,
  input  logic [7:0]    ld_data,
  output logic          ld_ready,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdata,
  input  logic [7:0]    mem_rdata,
  output logic          core_reset,
  output logic          req,
  input  logic          done,
  output logic          res_valid,
  output logic [7:0]    res_data,
  output logic [AW-1:0] res_addr,
  input  logic          res_ready,
  output logic          busy,
  output logic          finished,
  output logic          timeout,
  output logic [15:0]   run_cycles
);

  typedef enum logic [2:0] {
    IDLE, LOAD, LAUNCH, ARM, WAIT, DRAIN, DONE_S, TMO
  } state_t;

  // Pointers carry one extra bit so a full 2^AW transfer still has a
  // distinct last index.
  localparam int              PW          = AW + 1;
  localparam logic [AW-1:0]   LOAD_BASE_A = AW'(LOAD_BASE);
  localparam logic [AW-1:0]   RES_BASE_A  = AW'(RES_BASE);
  localparam logic [PW-1:0]   LOAD_LAST   = PW'(LOAD_N - 1);
  localparam logic [PW-1:0]   RES_LAST    = PW'(RES_N - 1);
  localparam logic [PW-1:0]   PTR_ONE     = PW'(1);
  localparam logic [16:0]     TMO_LIM     = 17'(TMO_CYC);

`ifdef HOST_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  state_t          state, state_next;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic            timeout_q;
  logic            start_ok;
  logic            at_limit;
  logic            tmo_hit;
  logic [AW-1:0]   load_addr;
  logic [AW-1:0]   drain_addr;

  // Address sums wrap naturally in AW bits.
  assign load_addr  = LOAD_BASE_A + wr_ptr[AW-1:0];
  assign drain_addr = RES_BASE_A + rd_ptr[AW-1:0];

  assign start_ok = start && (state == IDLE || state == DONE_S || state == TMO);

  // The current WAIT cycle is the one that brings run_cycles to the limit.
  assign at_limit = ({1'b0, run_cycles} + 17'd1) >= TMO_LIM;
  assign tmo_hit  = TMO_EN && at_limit;

  assign timeout  = TMO_EN && timeout_q;

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  // NOTE: every combinational output gets a default before the case, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE_S, TMO: if (start) state_next = LOAD;
      LOAD:              if (ld_valid && wr_ptr == LOAD_LAST) state_next = LAUNCH;
      LAUNCH:            state_next = ARM;
      // ARM ignores done: a stale done from the core leaving reset is masked.
      ARM:               state_next = WAIT;
      WAIT: begin
        // done takes priority over a coinciding watchdog expiry
        if (done)         state_next = DRAIN;
        else if (tmo_hit) state_next = TMO;
      end
      DRAIN:             if (res_ready && rd_ptr == RES_LAST) state_next = DONE_S;
      default:           state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Output logic (Moore outputs plus the pass-through load/read data)
  // ---------------------------------------------------------------------
  always_comb begin
    core_reset = 1'b1;
    ld_ready   = 1'b0;
    mem_wr_en  = 1'b0;
    mem_addr   = load_addr;
    mem_wdata  = 8'h00;
    req        = 1'b0;
    res_valid  = 1'b0;
    res_data   = 8'h00;
    res_addr   = '0;
    busy       = 1'b0;
    case (state)
      LOAD: begin
        busy      = 1'b1;
        ld_ready  = 1'b1;
        mem_wr_en = ld_valid;
        if (ld_valid) mem_wdata = ld_data;
      end
      LAUNCH: begin
        busy       = 1'b1;
        core_reset = 1'b0;
        req        = 1'b1;
      end
      ARM, WAIT: begin
        busy       = 1'b1;
        core_reset = 1'b0;
      end
      DRAIN: begin
        // Driven only from rd_ptr, so data/address hold while res_ready is low.
        busy      = 1'b1;
        res_valid = 1'b1;
        mem_addr  = drain_addr;
        res_data  = mem_rdata;
        res_addr  = drain_addr;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------
  // Pointers, cycle counter and sticky status
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      run_cycles <= '0;
      finished   <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      if (start_ok) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        run_cycles <= '0;
        finished   <= 1'b0;
        timeout_q  <= 1'b0;
      end
      case (state)
        LOAD: if (ld_valid) wr_ptr <= wr_ptr + PTR_ONE;
        WAIT: begin
          if (run_cycles != 16'hFFFF) run_cycles <= run_cycles + 16'd1;
          if (!done && tmo_hit) timeout_q <= 1'b1;
        end
        DRAIN: begin
          if (res_ready) begin
            rd_ptr <= rd_ptr + PTR_ONE;
            if (rd_ptr == RES_LAST) finished <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_run_host.sv
// tb_run_host -- randomized scoreboard bench for run_host.
//
// The stimulus process drives sessions and pushes the expected memory writes
// and result bytes into queues; a negedge monitor pops and compares them as
// the DUT presents writes and results. A small core model answers req with
// done after a chosen number of WAIT cycles, and a byte-array memory stands
// in for the processor's data memory.

module tb_run_host;

  localparam int AW        = 8;
  localparam int LOAD_BASE = 0;
  localparam int LOAD_N    = 64;
  localparam int RES_BASE  = 64;
  localparam int RES_N     = 32;
  localparam int TMO_CYC   = 16;
  localparam int MSZ       = 1 << AW;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } xfer_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          ld_valid = 1'b0;
  logic [7:0]    ld_data = 8'h00;
  logic          ld_ready;
  logic          mem_wr_en;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata;
  logic          core_reset;
  logic          req;
  logic          done = 1'b0;
  logic          res_valid;
  logic [7:0]    res_data;
  logic [AW-1:0] res_addr;
  logic          res_ready = 1'b1;
  logic          busy;
  logic          finished;
  logic          timeout;
  logic [15:0]   run_cycles;

  run_host #(
    .AW(AW), .LOAD_BASE(LOAD_BASE), .LOAD_N(LOAD_N),
    .RES_BASE(RES_BASE), .RES_N(RES_N), .TMO_CYC(TMO_CYC)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
    .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .core_reset(core_reset), .req(req), .done(done),
    .res_valid(res_valid), .res_data(res_data), .res_addr(res_addr),
    .res_ready(res_ready),
    .busy(busy), .finished(finished), .timeout(timeout), .run_cycles(run_cycles)
  );

  always #5 clk = ~clk;

  // ---------------- environment memory ----------------
  logic [7:0]    mem [MSZ];
  logic          fill_en = 1'b0;
  logic [AW-1:0] fill_addr = '0;
  logic [7:0]    fill_data = 8'h00;

  always @(posedge clk) begin
    if (fill_en)        mem[fill_addr] <= fill_data;
    else if (mem_wr_en) mem[mem_addr]  <= mem_wdata;
  end
  assign mem_rdata = mem[mem_addr];

  // ---------------- reference model state ----------------
  logic [7:0] ref_mem [MSZ];
  xfer_t      exp_wr[$];
  xfer_t      exp_res[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- core model ----------------
  // mode 0: done rises in WAIT cycle done_lat; mode 1: done stuck high;
  // mode 2: done never asserted.
  int done_mode = 0;
  int done_lat  = 1;
  int done_cnt  = 0;

  always @(negedge clk) begin
    if (reset) begin
      done_cnt = 0;
      done     = (done_mode == 1);
    end else if (done_mode == 1) begin
      done = 1'b1;
    end else if (done_mode == 2) begin
      done     = 1'b0;
      done_cnt = 0;
    end else begin
      if (core_reset) done = 1'b0;
      if (req) done_cnt = done_lat + 1;
      else if (done_cnt > 0) begin
        done_cnt--;
        if (done_cnt == 0) done = 1'b1;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int    wr_count = 0;
  int    wr_base  = 0;
  int    n_req    = 0;
  int    drained  = 0;
  xfer_t mon_e;

  always @(negedge clk) begin
    if (!reset) begin
      if (mem_wr_en) begin
        check("wr_expected", 32'(exp_wr.size() != 0), 1);
        if (exp_wr.size() != 0) begin
          mon_e = exp_wr.pop_front();
          check("wr_addr", 32'(mem_addr), 32'(mon_e.addr));
          check("wr_data", 32'(mem_wdata), 32'(mon_e.data));
        end
        wr_count++;
      end
      if (req) begin
        n_req++;
        check("req_after_last_byte", wr_count - wr_base, LOAD_N);
        check("req_core_released", 32'(core_reset), 0);
      end
      if (res_valid) begin
        check("res_expected", 32'(exp_res.size() != 0), 1);
        if (exp_res.size() != 0) begin
          mon_e = exp_res[0];
          check(res_ready ? "res_addr" : "res_addr_hold", 32'(res_addr), 32'(mon_e.addr));
          check(res_ready ? "res_data" : "res_data_hold", 32'(res_data), 32'(mon_e.data));
          if (res_ready) begin
            mon_e = exp_res.pop_front();
            drained++;
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_results();
    for (int i = 0; i < RES_N; i++) begin
      logic [AW-1:0] a;
      logic [7:0]    d;
      a = AW'(RES_BASE + i);
      d = 8'($urandom);
      fill_en = 1'b1; fill_addr = a; fill_data = d;
      ref_mem[a] = d;
      tick();
    end
    fill_en = 1'b0;
  endtask

  task automatic do_start();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic load_all(input bit gaps);
    for (int k = 0; k < LOAD_N; k++) begin
      logic [7:0]    b;
      logic [AW-1:0] a;
      int            wait_cyc;
      b = 8'($urandom);
      a = AW'(LOAD_BASE + k);
      ld_valid = 1'b1;
      ld_data  = b;
      wait_cyc = 0;
      while (!ld_ready && wait_cyc < 100) begin
        tick();
        wait_cyc++;
      end
      if (!ld_ready) begin
        check("ld_ready_within_budget", 32'(ld_ready), 1);
        ld_valid = 1'b0;
        return;
      end
      exp_wr.push_back('{addr: a, data: b});
      ref_mem[a] = b;
      tick();
      ld_valid = 1'b0;
      ld_data  = 8'($urandom);
      if (gaps) tick();
    end
  endtask

  task automatic session(input int lat, input int mode, input bit gaps,
                         input int bp_at, input bit expect_tmo, input bit noise);
    int budget, hold, req_base, drn_base, exp_run;
    fill_results();
    done_mode = mode;
    done_lat  = lat;
    req_base  = n_req;
    drn_base  = drained;
    wr_base   = wr_count;
    hold      = 0;
    exp_run   = (mode == 0) ? lat : (mode == 1) ? 1 : TMO_CYC;
    if (mode == 1) tick();   // let done settle high before start
    do_start();
    check("start_clears_finished", 32'(finished), 0);
    check("start_clears_run_cycles", 32'(run_cycles), 0);
    check("busy_in_load", 32'(busy), 1);
    load_all(gaps);
    if (!expect_tmo)
      for (int i = 0; i < RES_N; i++) begin
        logic [AW-1:0] a;
        a = AW'(RES_BASE + i);
        exp_res.push_back('{addr: a, data: ref_mem[a]});
      end
    budget = 0;
    while (!finished && !timeout && budget < 1000) begin
      res_ready = !(bp_at >= 0 && res_valid && (drained - drn_base) == bp_at && hold < 3);
      if (!res_ready) hold++;
      start = noise && busy && ($urandom_range(0, 5) == 0);
      tick();
      budget++;
    end
    start     = 1'b0;
    res_ready = 1'b1;
    check("session_ends_in_budget", 32'(budget < 1000), 1);
    check("finished_flag", 32'(finished), 32'(!expect_tmo));
    check("timeout_flag", 32'(timeout), 32'(expect_tmo));
    check("run_cycles", 32'(run_cycles), exp_run);
    check("busy_after", 32'(busy), 0);
    check("core_reset_after", 32'(core_reset), 1);
    check("req_pulses", n_req - req_base, 1);
    check("results_drained", drained - drn_base, expect_tmo ? 0 : RES_N);
    check("results_left", exp_res.size(), 0);
    check("writes_left", exp_wr.size(), 0);
    repeat (3) tick();
    check("no_restart_when_idle", 32'(busy), 0);
  endtask

  task automatic reset_mid_wait();
    int req_base;
    fill_results();
    done_mode = 0;
    done_lat  = 12;
    req_base  = n_req;
    wr_base   = wr_count;
    do_start();
    load_all(1'b0);
    repeat (5) tick();     // LAUNCH -> ARM -> WAIT cycle 4
    check("mid_wait_busy", 32'(busy), 1);
    check("mid_wait_core_running", 32'(core_reset), 0);
    check("mid_wait_run_cycles", 32'(run_cycles), 3);
    check("mid_wait_req_seen", n_req - req_base, 1);
    reset = 1'b1;
    tick();
    check("rst_core_reset", 32'(core_reset), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_finished", 32'(finished), 0);
    check("rst_run_cycles", 32'(run_cycles), 0);
    check("rst_mem_addr", 32'(mem_addr), LOAD_BASE);
    reset = 1'b0;
    repeat (20) tick();
    check("rst_stays_idle", 32'(busy), 0);
    check("rst_no_writes", wr_count - wr_base, LOAD_N);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    ld_valid = 1'b1;           // must not leak through while in reset
    ld_data  = 8'hA5;
    repeat (3) tick();
    check("reset_core_reset", 32'(core_reset), 1);
    check("reset_busy", 32'(busy), 0);
    check("reset_ld_ready", 32'(ld_ready), 0);
    check("reset_mem_wr_en", 32'(mem_wr_en), 0);
    check("reset_mem_wdata", 32'(mem_wdata), 0);
    check("reset_mem_addr", 32'(mem_addr), LOAD_BASE);
    check("reset_req", 32'(req), 0);
    check("reset_res_valid", 32'(res_valid), 0);
    check("reset_res_addr", 32'(res_addr), 0);
    check("reset_finished", 32'(finished), 0);
    check("reset_timeout", 32'(timeout), 0);
    check("reset_run_cycles", 32'(run_cycles), 0);
    ld_valid = 1'b0;
    reset    = 1'b0;
    tick();

    session(10, 0, 1'b0, -1, 1'b0, 1'b0);   // basic
    session(7,  0, 1'b1, -1, 1'b0, 1'b0);   // load gaps
    session(1,  1, 1'b0, -1, 1'b0, 1'b0);   // stale done
    session(10, 0, 1'b0, 5,  1'b0, 1'b0);   // drain backpressure on byte 5
    reset_mid_wait();
    session(10, 0, 1'b0, -1, 1'b0, 1'b0);   // full session after reset
`ifdef HOST_TIMEOUT_EN
    session(1,  2, 1'b0, -1, 1'b1, 1'b0);   // watchdog expiry
`endif
    session(TMO_CYC, 0, 1'b0, -1, 1'b0, 1'b0);  // done on the last allowed cycle
    for (int s = 0; s < 6; s++)
      session(int'($urandom_range(1, TMO_CYC)), 0, 1'($urandom_range(0, 1)),
              int'($urandom_range(0, RES_N - 1)), 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_time_limit: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/run_host.md
# run_host

Host-side sequencer for the processor's req/done handshake, the initiator end of that interface. It preloads operand bytes into data memory through a byte-stream port and holds the core in reset while loading. It then launches the program with `req`, waits for `done`, and drains a result window from data memory back out through a valid/ready stream. It sits between the bench or off-chip link and the processor top level, sharing data-memory write and read access while the core is stopped.

## Interface
- `AW`, default 8: data-memory address width.
- `LOAD_BASE`, default 0: first address written during load.
- `LOAD_N`, default 64: bytes accepted per load phase (1..2^AW).
- `RES_BASE`, default 64: first address read during drain.
- `RES_N`, default 32: bytes emitted per drain phase (1..2^AW).
- `TMO_CYC`, default 4096: watchdog limit in cycles, used only with `HOST_TIMEOUT_EN`.
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `reset`, in, 1: synchronous, active-high; clears all state on the rising edge while high.
- `start`, in, 1: begin a session; sampled only in IDLE, DONE_S, TMO.
- `ld_valid`, in, 1: load byte present.
- `ld_data`, in, 8: load byte.
- `ld_ready`, out, 1: host accepts a load byte.
- `mem_wr_en`, out, 1: data-memory write strobe.
- `mem_addr`, out, AW: data-memory address, shared by writes and reads.
- `mem_wdata`, out, 8: data-memory write data.
- `mem_rdata`, in, 8: data-memory read data, combinational on `mem_addr`.
- `core_reset`, out, 1: reset to the processor.
- `req`, out, 1: launch strobe to the processor.
- `done`, in, 1: processor completion.
- `res_valid`, out, 1: result byte present.
- `res_data`, out, 8: result byte.
- `res_addr`, out, AW: memory address of `res_data`.
- `res_ready`, in, 1: downstream accepts a result byte.
- `busy`, out, 1: session in progress.
- `finished`, out, 1: sticky; last session drained normally.
- `timeout`, out, 1: sticky; last session aborted by the watchdog.
- `run_cycles`, out, 16: cycles spent in WAIT during the last or current session; saturates at 0xFFFF.

## Operation
- States are IDLE, LOAD, LAUNCH, ARM, WAIT, DRAIN, DONE_S and TMO.
- **IDLE**
  - `core_reset`=1.
  - `start` moves to LOAD and clears `wr_ptr`, `rd_ptr`, `run_cycles`, `finished` and `timeout`.
- **LOAD**
  - `core_reset`=1 and `ld_ready`=1.
  - On `ld_valid`: `mem_wr_en`=1, `mem_addr`=`LOAD_BASE`+`wr_ptr`, `mem_wdata`=`ld_data`.
  - `wr_ptr` increments on each accepted byte.
  - The write with `wr_ptr`=`LOAD_N`-1 moves to LAUNCH.
- **LAUNCH**
  - `core_reset`=0 and `req`=1 for exactly this one cycle.
  - Moves to ARM.
- **ARM**
  - One cycle; `done` is ignored here to mask any stale `done` from the core leaving reset.
  - Moves to WAIT.
- **WAIT**
  - `run_cycles` increments each cycle.
  - `done`=1 moves to DRAIN.
- **DRAIN**
  - `core_reset`=1.
  - `res_valid`=1, `mem_addr`=`RES_BASE`+`rd_ptr`, `res_data`=`mem_rdata`, `res_addr`=`mem_addr`.
  - On `res_ready`, `rd_ptr` increments.
  - The accept with `rd_ptr`=`RES_N`-1 moves to DONE_S and sets `finished`.
- **DONE_S / TMO**
  - `core_reset`=1.
  - `start` begins a new session exactly as from IDLE.
- **Output rules**
  - `busy`=1 in LOAD through DRAIN.
  - `ld_ready`, `mem_wr_en`, `req` and `res_valid` are 0 outside their own states.
  - `mem_addr` is `LOAD_BASE`+`wr_ptr` outside DRAIN.
- **Arithmetic**
  - Address sums wrap modulo 2^AW.
  - Pointers are AW+1 bits, so `LOAD_N`=2^AW terminates correctly.

## Timing
- **Reset values:** state IDLE, `core_reset`=1, all other outputs 0, `mem_addr`=`LOAD_BASE`.
- **Reset mid-session:** returns to IDLE on the next edge, aborts the session with no further writes, clears sticky flags.
- All `mem_*`, `ld_ready`, `req`, `res_*` and `busy` are combinational from registered state and pointers, plus `ld_valid`, `ld_data` and `mem_rdata`; there is no input-to-output path from `res_ready`.
- **Load throughput:** one byte per cycle; a stalled `ld_valid` leaves the state unchanged.
- **Launch latency:** minimum `req` pulse 1 cycle after the last load write; earliest `done` recognition is 2 cycles after `req`.
- **`run_cycles`:** counts every cycle spent in WAIT, including the cycle in which `done` is sampled.
- **Drain throughput:** one byte per cycle with `res_ready` held high; `res_data` and `res_addr` are stable while `res_valid`=1 and `res_ready`=0.
- **`start` while busy:** ignored.
- **`start` and `reset` together:** `reset` wins.

## Configuration
- `HOST_TIMEOUT_EN` defined:
  - A watchdog counts cycles in WAIT.
  - When `run_cycles` reaches `TMO_CYC` with no `done`, the next state is TMO, `timeout` is set, and the drain is skipped.
  - `done` and the limit coinciding: `done` wins (DRAIN).
- `HOST_TIMEOUT_EN` not defined:
  - WAIT persists until `done`.
  - TMO is unreachable and `timeout` is tied to 0.

## Test plan
- **Basic session:**
  - Stimulus: reset, `start`, 64 load bytes 0x00..0x3F back-to-back; core model asserts `done` 10 cycles after `req`; `res_ready`=1.
  - Response: writes to addresses 0..63; one `req` pulse; `run_cycles`=10; 32 results from addresses 64..95; `finished`=1.
- **Load gaps:**
  - Stimulus: `ld_valid` toggled every other cycle.
  - Response: exactly 64 writes, no duplicates; LAUNCH occurs only after the 64th byte.
- **Stale done:**
  - Stimulus: `done` held 1 from before `start`.
  - Response: `done` is ignored during LOAD, LAUNCH and ARM; DRAIN is entered on the first WAIT cycle; `run_cycles`=1.
- **Drain backpressure:**
  - Stimulus: `res_ready` low 3 cycles on byte 5.
  - Response: `res_addr`=69 and `res_data` held steady; no bytes lost or repeated.
- **Reset mid-WAIT:**
  - Stimulus: assert `reset` during WAIT.
  - Response: IDLE on the next edge, `core_reset`=1, `busy`=0, `finished`=0.
  - Stimulus: a following `start`.
  - Response: a full normal session.
- **Timeout** (`HOST_TIMEOUT_EN`, `TMO_CYC`=16):
  - Stimulus: `done` never asserted.
  - Response: `timeout`=1 after 16 WAIT cycles; no `res_valid`.
  - Stimulus: repeat with `done` on the 16th cycle.
  - Response: DRAIN.
